// File: rtl/uart_pkg.sv
// Shared UART core package: encodings and constants used across the core.
package uart_pkg;

    localparam logic DIR_DOWN     = 1'b0;
    localparam logic DIR_UP       = 1'b1;
    localparam logic MODE_AUTO    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/count_step.sv
// Next-count and terminal-detect logic for prog_counter.
module count_step
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] count,
    input  logic [N-1:0] rl,
    input  logic         dir,
    output logic [N-1:0] step,
    output logic [N-1:0] restart,
    output logic         at_term
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] term;

    always_comb begin
        term    = (dir == DIR_UP) ? rl : '0;
        restart = (dir == DIR_UP) ? '0 : rl;
        step    = (dir == DIR_UP) ? count + ONE : count - ONE;
        at_term = (count == term);
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with reload register, one-shot mode and tc pulse.
module prog_counter
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dir,
    input  logic         mode,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         busy
);

    logic [N-1:0] rl_q, rl_d;
    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         busy_q, busy_d;

    logic [N-1:0] step;
    logic [N-1:0] restart;
    logic         at_term;

    count_step #(.N(N)) u_step (
        .count   (count_q),
        .rl      (rl_q),
        .dir     (dir),
        .step    (step),
        .restart (restart),
        .at_term (at_term)
    );

    always_comb begin
        rl_d    = rl_q;
        count_d = count_q;
        tc_d    = 1'b0;
        busy_d  = busy_q;
        if (load) begin
            // Restart value is derived from the incoming modulus, not the old rl.
            rl_d    = load_val;
            count_d = (dir == DIR_UP) ? '0 : load_val;
            busy_d  = 1'b1;
        end else if (en && busy_q) begin
            if (at_term) begin
                tc_d = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    busy_d = 1'b0;
                end else begin
                    count_d = restart;
                end
            end else begin
                count_d = step;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!nreset) begin
            rl_q    <= '1;
            count_q <= '1;
            tc_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            rl_q    <= rl_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter (N=4, falling-edge design).
module tb_prog_counter;

    logic       clk;
    logic       nreset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       dir;
    logic       mode;
    logic [3:0] count;
    logic       tc;
    logic       busy;

    int total = 0;
    int bad   = 0;

    prog_counter #(.N(4)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
        .busy     (busy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Active edge is negedge; outputs are sampled on the following posedge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0; load = 1'b1; en = 1'b1;
        load_val = 4'd3; dir = 1'b0; mode = 1'b0;
        tick();
        total++;
        if ({count, tc, busy} !== {4'd15, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset: count=%0d tc=%0b busy=%0b want 15 0 1",
                     count, tc, busy);
        end
        load = 1'b0; en = 1'b0;
        tick();
        nreset = 1'b1;
    endtask

    task automatic test_free_run();
        logic [3:0] ec;
        logic       et;
        en = 1'b1; dir = 1'b0; mode = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            ec = 4'(15 - i);
            et = (i % 16 == 0);
            total++;
            if (count !== ec || tc !== et) begin
                bad++;
                $display("FAIL free_run[%0d]: count=%0d tc=%0b want %0d %0b",
                         i, count, tc, ec, et);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] ec;
        load = 1'b1; load_val = 4'd5; dir = 1'b0; mode = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if ({count, tc, busy} !== {4'd5, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL oneshot_load: count=%0d tc=%0b busy=%0b want 5 0 1",
                     count, tc, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            ec = 4'(5 - i);
            total++;
            if ({count, tc, busy} !== {ec, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL oneshot_run[%0d]: count=%0d tc=%0b busy=%0b want %0d 0 1",
                         i, count, tc, busy, ec);
            end
        end
        tick();
        total++;
        if ({count, tc, busy} !== {4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL oneshot_term: count=%0d tc=%0b busy=%0b want 0 1 0",
                     count, tc, busy);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({count, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL oneshot_hold[%0d]: count=%0d tc=%0b busy=%0b want 0 0 0",
                         i, count, tc, busy);
            end
        end
    endtask

    task automatic test_up_auto();
        logic [3:0] ec;
        logic       et;
        load = 1'b1; load_val = 4'd3; dir = 1'b1; mode = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if (count !== 4'd0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL up_load: count=%0d tc=%0b want 0 0", count, tc);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            ec = 4'(i % 4);
            et = (i % 4 == 0);
            total++;
            if (count !== ec || tc !== et) begin
                bad++;
                $display("FAIL up_auto[%0d]: count=%0d tc=%0b want %0d %0b",
                         i, count, tc, ec, et);
            end
        end
    endtask

    task automatic test_zero();
        load = 1'b1; load_val = 4'd0; dir = 1'b0; mode = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (count !== 4'd0 || tc !== 1'b1) begin
                bad++;
                $display("FAIL zero[%0d]: count=%0d tc=%0b want 0 1",
                         i, count, tc);
            end
        end
    endtask

    task automatic test_hold_and_load();
        load = 1'b1; load_val = 4'd12; dir = 1'b0; mode = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        total++;
        if (count !== 4'd9) begin
            bad++;
            $display("FAIL hold_pre: count=%0d want 9", count);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count !== 4'd9 || tc !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: count=%0d tc=%0b want 9 0",
                         i, count, tc);
            end
        end
        load = 1'b1; en = 1'b1; load_val = 4'd6;
        tick();
        load = 1'b0;
        total++;
        if (count !== 4'd6 || tc !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load_wins: count=%0d tc=%0b busy=%0b want 6 0 1",
                     count, tc, busy);
        end
        tick();
        total++;
        if (count !== 4'd5) begin
            bad++;
            $display("FAIL after_load: count=%0d want 5", count);
        end
    endtask

    task automatic test_reset_oneshot();
        load = 1'b1; load_val = 4'd7; dir = 1'b1; mode = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        total++;
        if ({count, tc, busy} !== {4'd7, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rst_os_pre: count=%0d tc=%0b busy=%0b want 7 1 0",
                     count, tc, busy);
        end
        tick();
        nreset = 1'b0; load = 1'b1; load_val = 4'd2;
        tick();
        nreset = 1'b1; load = 1'b0;
        total++;
        if ({count, tc, busy} !== {4'd15, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_os: count=%0d tc=%0b busy=%0b want 15 0 1",
                     count, tc, busy);
        end
        // Counting up from 15 only hits terminal if rl was restored to 15.
        mode = 1'b0;
        tick();
        total++;
        if (count !== 4'd0 || tc !== 1'b1) begin
            bad++;
            $display("FAIL rst_rl: count=%0d tc=%0b want 0 1", count, tc);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_oneshot();
        test_up_auto();
        test_zero();
        test_hold_and_load();
        test_reset_oneshot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
